// File: rtl/trace_chk_pkg.sv
// Shared types for the commit trace checker: checker states and first-error codes.
package trace_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_PC      = 3'd1,
    ERR_RD      = 3'd2,
    ERR_DATA    = 3'd3,
    ERR_EXTRA   = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_code_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Top pointer bit distinguishes full from empty when the index bits coincide
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares a DUT commit stream against a golden trace, latching the first divergence.
module commit_trace_checker
  import trace_chk_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int Q_DEPTH     = 4,
  parameter int WDOG_CYCLES = 5000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cm_valid,
  output logic            cm_ready,
  input  logic [XLEN-1:0] cm_pc,
  input  logic            cm_uses_rd,
  input  logic [4:0]      cm_rd,
  input  logic [XLEN-1:0] cm_data,
  input  logic            gd_valid,
  output logic            gd_ready,
  input  logic [XLEN-1:0] gd_pc,
  input  logic            gd_uses_rd,
  input  logic [4:0]      gd_rd,
  input  logic [XLEN-1:0] gd_data,
  input  logic            gd_last,
  output logic            busy,
  output logic            pass,
  output logic            fail,
  output logic [2:0]      err_code,
  output logic [31:0]     err_idx,
  output logic [31:0]     match_cnt,
  output logic [XLEN-1:0] exp_pc,
  output logic [XLEN-1:0] got_pc
);

  localparam int ENTRY_W = 2 * XLEN + 6;
  localparam int WDOG_W  = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);

  state_e            state_q, state_d;
  err_code_e         err_code_q, err_code_d, cmp_code;
  logic [31:0]       err_idx_q, err_idx_d;
  logic [31:0]       match_cnt_q, match_cnt_d;
  logic [XLEN-1:0]   exp_pc_q, exp_pc_d;
  logic [XLEN-1:0]   got_pc_q, got_pc_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic               fifo_full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic [XLEN-1:0]    head_pc, head_data;
  logic               head_uses_rd;
  logic [4:0]         head_rd;

  assign cm_ready = ((state_q == ST_RUN) && !fifo_full) || (state_q == ST_PASS);
  assign gd_ready = (state_q == ST_RUN) && !fifo_empty;
  assign push     = cm_valid && cm_ready && (state_q == ST_RUN);
  assign pop      = gd_valid && gd_ready;

  assign fifo_din = {cm_pc, cm_uses_rd, cm_rd, cm_data};
  assign {head_pc, head_uses_rd, head_rd, head_data} = fifo_dout;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (Q_DEPTH)
  ) u_commit_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Data is only meaningful when a nonzero rd is written; x0 writes are architecturally dropped
  always_comb begin
    cmp_code = ERR_NONE;
    if (gd_pc != head_pc)
      cmp_code = ERR_PC;
    else if ((gd_uses_rd != head_uses_rd) || (gd_rd != head_rd))
      cmp_code = ERR_RD;
    else if (head_uses_rd && (head_rd != 5'd0) && (gd_data != head_data))
      cmp_code = ERR_DATA;
  end

  always_comb begin
    state_d     = state_q;
    err_code_d  = err_code_q;
    err_idx_d   = err_idx_q;
    match_cnt_d = match_cnt_q;
    exp_pc_d    = exp_pc_q;
    got_pc_d    = got_pc_q;
    wdog_d      = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          wdog_d  = '0;
        end
      end
      ST_RUN: begin
        wdog_d = push ? '0 : wdog_q + WDOG_ONE;
        if (pop && (cmp_code != ERR_NONE)) begin
          state_d    = ST_FAIL;
          err_code_d = cmp_code;
          err_idx_d  = match_cnt_q;
          exp_pc_d   = gd_pc;
          got_pc_d   = head_pc;
        end else begin
          if (pop) begin
            match_cnt_d = match_cnt_q + 32'd1;
            if (gd_last) state_d = ST_PASS;
          end
          if ((state_d == ST_RUN) && (wdog_d == WDOG_LIMIT)) begin
            state_d    = ST_FAIL;
            err_code_d = ERR_TIMEOUT;
            err_idx_d  = match_cnt_d;
          end
        end
      end
      ST_PASS: begin
        if (cm_valid) begin
          state_d    = ST_FAIL;
          err_code_d = ERR_EXTRA;
          err_idx_d  = match_cnt_q;
          got_pc_d   = cm_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      err_code_q  <= ERR_NONE;
      err_idx_q   <= '0;
      match_cnt_q <= '0;
      exp_pc_q    <= '0;
      got_pc_q    <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      err_idx_q   <= err_idx_d;
      match_cnt_q <= match_cnt_d;
      exp_pc_q    <= exp_pc_d;
      got_pc_q    <= got_pc_d;
      wdog_q      <= wdog_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);
  assign err_code  = err_code_q;
  assign err_idx   = err_idx_q;
  assign match_cnt = match_cnt_q;
  assign exp_pc    = exp_pc_q;
  assign got_pc    = got_pc_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: pass, mismatch codes, backpressure, timeout, reset.
module tb_commit_trace_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cm_valid, cm_ready, cm_uses_rd;
  logic [31:0] cm_pc, cm_data;
  logic [4:0]  cm_rd;
  logic        gd_valid, gd_ready, gd_uses_rd, gd_last;
  logic [31:0] gd_pc, gd_data;
  logic [4:0]  gd_rd;
  logic        busy, pass, fail;
  logic [2:0]  err_code;
  logic [31:0] err_idx, match_cnt, exp_pc, got_pc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  commit_trace_checker #(
    .XLEN        (32),
    .Q_DEPTH     (4),
    .WDOG_CYCLES (5000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cm_valid   (cm_valid),
    .cm_ready   (cm_ready),
    .cm_pc      (cm_pc),
    .cm_uses_rd (cm_uses_rd),
    .cm_rd      (cm_rd),
    .cm_data    (cm_data),
    .gd_valid   (gd_valid),
    .gd_ready   (gd_ready),
    .gd_pc      (gd_pc),
    .gd_uses_rd (gd_uses_rd),
    .gd_rd      (gd_rd),
    .gd_data    (gd_data),
    .gd_last    (gd_last),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .err_code   (err_code),
    .err_idx    (err_idx),
    .match_cnt  (match_cnt),
    .exp_pc     (exp_pc),
    .got_pc     (got_pc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic setCommit(input logic v, input logic [31:0] pc, input logic u,
                           input logic [4:0] rd, input logic [31:0] data);
    cm_valid   = v;
    cm_pc      = pc;
    cm_uses_rd = u;
    cm_rd      = rd;
    cm_data    = data;
  endtask

  task automatic setGolden(input logic v, input logic [31:0] pc, input logic u,
                           input logic [4:0] rd, input logic [31:0] data, input logic last);
    gd_valid   = v;
    gd_pc      = pc;
    gd_uses_rd = u;
    gd_rd      = rd;
    gd_data    = data;
    gd_last    = last;
  endtask

  // All stimulus is quiesced before the reset edge so nothing leaks into the next run
  task automatic applyStimulus(input logic do_reset, input logic do_start);
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    setGolden(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    if (do_reset) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    setGolden(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_fail", 32'(fail), 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    checkOutput("rst_err_idx", err_idx, 32'd0);
    checkOutput("rst_match_cnt", match_cnt, 32'd0);
    checkOutput("rst_exp_pc", exp_pc, 32'd0);
    checkOutput("rst_got_pc", got_pc, 32'd0);
    checkOutput("rst_cm_ready", 32'(cm_ready), 32'd0);
    checkOutput("rst_gd_ready", 32'(gd_ready), 32'd0);
    rst_n = 1'b1;

    // Three matching records, third one last
    applyStimulus(1'b0, 1'b1);
    checkOutput("run_busy", 32'(busy), 32'd1);
    checkOutput("run_cm_ready", 32'(cm_ready), 32'd1);
    checkOutput("run_gd_ready_empty", 32'(gd_ready), 32'd0);
    setCommit(1'b1, 32'h0, 1'b1, 5'd1, 32'h11); tick();
    setCommit(1'b1, 32'h4, 1'b1, 5'd2, 32'h22); tick();
    setCommit(1'b1, 32'h8, 1'b0, 5'd0, 32'h0);  tick();
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("run_gd_ready_queued", 32'(gd_ready), 32'd1);
    setGolden(1'b1, 32'h0, 1'b1, 5'd1, 32'h11, 1'b0); tick();
    setGolden(1'b1, 32'h4, 1'b1, 5'd2, 32'h22, 1'b0); tick();
    setGolden(1'b1, 32'h8, 1'b0, 5'd0, 32'h0, 1'b1);  tick();
    setGolden(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("p3_pass", 32'(pass), 32'd1);
    checkOutput("p3_busy", 32'(busy), 32'd0);
    checkOutput("p3_match_cnt", match_cnt, 32'd3);
    checkOutput("p3_cm_ready", 32'(cm_ready), 32'd1);
    checkOutput("p3_gd_ready", 32'(gd_ready), 32'd0);

    // Extra commit after PASS
    setCommit(1'b1, 32'h40, 1'b0, 5'd0, 32'h0); tick();
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("extra_fail", 32'(fail), 32'd1);
    checkOutput("extra_pass", 32'(pass), 32'd0);
    checkOutput("extra_err_code", 32'(err_code), 32'd4);
    checkOutput("extra_err_idx", err_idx, 32'd3);

    // PC mismatch on second record
    applyStimulus(1'b1, 1'b1);
    setCommit(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);  tick();
    setCommit(1'b1, 32'h10, 1'b0, 5'd0, 32'h0); tick();
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    setGolden(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    setGolden(1'b1, 32'hC, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    setGolden(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("pc_fail", 32'(fail), 32'd1);
    checkOutput("pc_err_code", 32'(err_code), 32'd1);
    checkOutput("pc_err_idx", err_idx, 32'd1);
    checkOutput("pc_exp_pc", exp_pc, 32'hC);
    checkOutput("pc_got_pc", got_pc, 32'h10);
    checkOutput("pc_match_cnt", match_cnt, 32'd1);
    checkOutput("pc_cm_ready", 32'(cm_ready), 32'd0);
    checkOutput("pc_gd_ready", 32'(gd_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("pc_sticky_fail", 32'(fail), 32'd1);
    checkOutput("pc_sticky_code", 32'(err_code), 32'd1);

    // rd=0 ignores data; rd=5 data mismatch
    applyStimulus(1'b1, 1'b1);
    setCommit(1'b1, 32'h0, 1'b1, 5'd0, 32'h1); tick();
    setCommit(1'b1, 32'h4, 1'b1, 5'd5, 32'h1); tick();
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    setGolden(1'b1, 32'h0, 1'b1, 5'd0, 32'h2, 1'b0); tick();
    checkOutput("x0_match_cnt", match_cnt, 32'd1);
    checkOutput("x0_no_fail", 32'(fail), 32'd0);
    setGolden(1'b1, 32'h4, 1'b1, 5'd5, 32'h2, 1'b0); tick();
    setGolden(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("data_fail", 32'(fail), 32'd1);
    checkOutput("data_err_code", 32'(err_code), 32'd3);
    checkOutput("data_err_idx", err_idx, 32'd1);

    // Backpressure: five back-to-back commits, golden held off
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      setCommit(1'b1, 32'(i * 4), 1'b0, 5'd0, 32'h0);
      checkOutput($sformatf("bp_ready_%0d", i), 32'(cm_ready), 32'd1);
      tick();
    end
    setCommit(1'b1, 32'h10, 1'b0, 5'd0, 32'h0);
    checkOutput("bp_full_ready", 32'(cm_ready), 32'd0);
    tick();
    checkOutput("bp_still_full", 32'(cm_ready), 32'd0);
    setGolden(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    checkOutput("bp_ready_after_pop", 32'(cm_ready), 32'd1);
    setGolden(1'b1, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    setGolden(1'b1, 32'h8, 1'b0, 5'd0, 32'h0, 1'b0);  tick();
    setGolden(1'b1, 32'hC, 1'b0, 5'd0, 32'h0, 1'b0);  tick();
    setGolden(1'b1, 32'h10, 1'b0, 5'd0, 32'h0, 1'b1); tick();
    setGolden(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("bp_pass", 32'(pass), 32'd1);
    checkOutput("bp_match_cnt", match_cnt, 32'd5);

    // Watchdog: RUN with no commits
    applyStimulus(1'b1, 1'b1);
    repeat (4999) tick();
    checkOutput("wdog_before", 32'(fail), 32'd0);
    tick();
    checkOutput("wdog_fail", 32'(fail), 32'd1);
    checkOutput("wdog_err_code", 32'(err_code), 32'd5);

    // Reset with queued commits, then a clean run
    applyStimulus(1'b1, 1'b1);
    setCommit(1'b1, 32'h0, 1'b0, 5'd0, 32'h0); tick();
    setCommit(1'b1, 32'h4, 1'b0, 5'd0, 32'h0); tick();
    checkOutput("mid_gd_ready", 32'(gd_ready), 32'd1);
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0; tick();
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_gd_ready", 32'(gd_ready), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("fresh_empty", 32'(gd_ready), 32'd0);
    setCommit(1'b1, 32'h20, 1'b1, 5'd3, 32'h33); tick();
    setCommit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    setGolden(1'b1, 32'h20, 1'b1, 5'd3, 32'h33, 1'b1); tick();
    setGolden(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("fresh_pass", 32'(pass), 32'd1);
    checkOutput("fresh_match_cnt", match_cnt, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
